bram_readback_checker: RTL and testbench
========================================

# bram_readback_checker

Downstream consumer of the BRAM write/read test sequencer. It watches the sequencer's read port and pairs each read request with the BRAM data that returns `RD_LATENCY` cycles later. Each returned word is compared against the sequencer's counting write pattern, where expected data = `rd_addr[15:0] + SEED`. At the end of every write/read pass it reports a pass/fail verdict, error statistics and the first failing location, ready for debug probing.

## Interface
Parameters:
- `BRAM_SIZE`, 2048: reads expected per pass.
- `RD_LATENCY`, 1: BRAM read latency in cycles; legal range 1..4.
- `SEED`, 16'h0000: data value written at address 0.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-low reset.
- `rw_active` in 1: sequencer busy flag; high for the whole WR+RD pass.
- `rd_en` in 1: sequencer read strobe.
- `rd_addr` in 20: read address, valid with `rd_en`.
- `rd_data` in 16: BRAM read data, valid `RD_LATENCY` cycles after `rd_en`.
- `done` out 1: one-cycle pulse at the end of a pass.
- `pass` out 1: verdict of the last completed pass; held until the next `done`.
- `err_count` out 16: mismatches in the current/last pass; saturates at 16'hFFFF.
- `check_count` out 20: compares performed in the current/last pass.
- `first_err_addr` out 20: address of the first mismatch in the pass.
- `first_err_data` out 16: data read at the first mismatch.
- `sticky_fail` out 1: set by any failed pass; see Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, REPORT. Reset state is IDLE.
- IDLE → RUN when `rw_active`=1. Entry clears `err_count`, `check_count`, `first_err_addr` and `first_err_data` to 0. `pass` is not cleared on entry.
- RUN: each `rd_en`=1 cycle pushes {valid, `rd_addr`} into a `RD_LATENCY`-deep shift line.
- RUN → DRAIN when `rw_active`=0.
- DRAIN: no new pushes. The state lasts exactly `RD_LATENCY` cycles so that in-flight reads complete, then moves to REPORT.
- REPORT: lasts one cycle and asserts `done`.
  - `pass` ← (`err_count`==0 && `check_count`==`BRAM_SIZE`).
  - Then → IDLE.
- Compare stage, active in RUN and DRAIN: when the shift-line head is valid, compute expected = head_addr[15:0] + `SEED` (16-bit, modulo 2^16).
  - `check_count` += 1.
  - On mismatch: `err_count` += 1, saturating.
  - If this is the first mismatch of the pass, latch `first_err_addr`/`first_err_data`.
- `rd_en` in IDLE or REPORT is ignored.
- `rd_en` in DRAIN is ignored; it is a protocol violation.
- `check_count` wraps at 2^20. The value is reachable only if `BRAM_SIZE` is misconfigured; no special handling.
- A pass with zero reads, or a count other than `BRAM_SIZE`, gives `pass`=0 even with `err_count`=0.
- `rw_active` still or again high on return to IDLE starts a new pass on the next cycle.
- `rst`=0 at any time, including mid-pass: all state and outputs return to reset values on the next edge. The shift line is flushed and no `done` is issued.

## Timing
- Reset values: `done`=0, `pass`=0, `err_count`=0, `check_count`=0, `first_err_addr`=0, `first_err_data`=0, `sticky_fail`=0.
- `rd_en` sampled at edge N; `rd_data` sampled at edge N+`RD_LATENCY`.
- Counters and first-error registers are visible after edge N+`RD_LATENCY`+1.
- `rw_active` falls, sampled at edge M: DRAIN occupies cycles M+1..M+`RD_LATENCY`; `done`/`pass` update at edge M+`RD_LATENCY`+1.
- One read per cycle is sustained with no back-pressure. Back-to-back passes lose no reads provided `rw_active` stays low at least `RD_LATENCY`+2 cycles between passes.

## Configuration
- `BRAM_CHECKER_STICKY_FAIL_EN` defined:
  - `sticky_fail` sets at any REPORT with `pass`=0.
  - It is cleared only by `rst`.
- `BRAM_CHECKER_STICKY_FAIL_EN` undefined:
  - `sticky_fail` is tied to 0 and the register is not built.
  - All other behaviour is identical.

## Test plan
- Clean pass, `RD_LATENCY`=1, `SEED`=0: 2048 reads at addr 0..2047, data=addr → `done` pulse, `pass`=1, `err_count`=0, `check_count`=2048.
- Single corruption: data at addr 100 = 16'hDEAD → `pass`=0, `err_count`=1, `first_err_addr`=100, `first_err_data`=16'hDEAD.
- Short pass: only 2047 reads, all correct → `pass`=0, `err_count`=0, `check_count`=2047.
- `RD_LATENCY`=3, last read on the final RUN cycle: that read's mismatch is counted before `done`, which occurs 4 cycles after `rw_active` falls.
- `rst` low for 1 cycle mid-pass after 500 reads → all outputs 0, no `done`. The following full clean pass → `pass`=1, `check_count`=2048.
- With macro defined: failing pass then clean pass → `sticky_fail`=1 persists with `pass`=1. Without macro: `sticky_fail`=0 throughout.

Source files
------------

// File: rtl/bram_readback_checker.sv
// -----------------------------------------------------------------------------
// bram_readback_checker
//
// Watches the read port of the BRAM write/read test sequencer, pairs every
// read request with the data that returns RD_LATENCY cycles later and checks
// it against the counting write pattern (data = addr[15:0] + SEED). At the end
// of every write/read pass a one-cycle done pulse is issued together with a
// pass/fail verdict, error statistics and the first failing location.
//
// Optional feature (compile-time macro):
//   BRAM_CHECKER_STICKY_FAIL_EN - builds a sticky_fail flag that sets on any
//                                 failed pass and clears only on reset. When
//                                 undefined, sticky_fail is tied to 0.
//
// Ports:
//   clk            in   1  single clock
//   rst            in   1  synchronous, active-low reset
//   rw_active      in   1  sequencer busy for the whole WR+RD pass
//   rd_en          in   1  sequencer read strobe
//   rd_addr        in  20  read address, valid with rd_en
//   rd_data        in  16  BRAM data, valid RD_LATENCY cycles after rd_en
//   done           out  1  one-cycle pulse at the end of a pass
//   pass           out  1  verdict of the last completed pass
//   err_count      out 16  mismatches in current/last pass (saturating)
//   check_count    out 20  compares in current/last pass (wrapping)
//   first_err_addr out 20  address of the first mismatch of the pass
//   first_err_data out 16  data read at the first mismatch of the pass
//   sticky_fail    out  1  set by any failed pass (feature dependent)
// -----------------------------------------------------------------------------
module bram_readback_checker #(
    parameter int          BRAM_SIZE  = 2048,
    parameter int          RD_LATENCY = 1,
    parameter logic [15:0] SEED       = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rw_active,
    input  logic        rd_en,
    input  logic [19:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [19:0] check_count,
    output logic [19:0] first_err_addr,
    output logic [15:0] first_err_data,
    output logic        sticky_fail
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      drain_cnt_q, drain_cnt_d;

    // Shift line carrying {valid, addr} of in-flight reads; the head lines up
    // with rd_data of the same read.
    logic [RD_LATENCY-1:0] line_vld_q;
    logic [19:0]           line_addr_q [RD_LATENCY];

    logic [15:0] err_count_q, err_count_d;
    logic [19:0] check_count_q, check_count_d;
    logic [19:0] first_err_addr_q, first_err_addr_d;
    logic [15:0] first_err_data_q, first_err_data_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;

    logic        start_s;
    logic        push_s;
    logic        head_vld_s;
    logic        mismatch_s;
    logic [15:0] exp_data_s;

    // Counting write pattern of the sequencer.
    function automatic logic [15:0] expected_word(input logic [15:0] addr_lo);
        return addr_lo + SEED;
    endfunction

    assign start_s    = (state_q == ST_IDLE) && rw_active;
    assign push_s     = (state_q == ST_RUN) && rd_en;
    assign head_vld_s = line_vld_q[RD_LATENCY-1] &&
                        ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign exp_data_s = expected_word(line_addr_q[RD_LATENCY-1][15:0]);
    assign mismatch_s = head_vld_s && (rd_data != exp_data_s);

    // Next-state logic of the pass sequencing FSM.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rw_active) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!rw_active) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 3'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Stay exactly RD_LATENCY cycles so the last read returns.
                if (drain_cnt_q == 3'(RD_LATENCY - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Compare stage, statistics and end-of-pass verdict.
    always_comb begin
        err_count_d      = err_count_q;
        check_count_d    = check_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        pass_d           = pass_q;
        done_d           = 1'b0;
        if (start_s) begin
            err_count_d      = 16'd0;
            check_count_d    = 20'd0;
            first_err_addr_d = 20'd0;
            first_err_data_d = 16'd0;
        end else if (head_vld_s) begin
            check_count_d = check_count_q + 20'd1;
            if (mismatch_s) begin
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end else begin
                    err_count_d = err_count_q;
                end
                // A zero error count means no mismatch yet in this pass.
                if (err_count_q == 16'd0) begin
                    first_err_addr_d = line_addr_q[RD_LATENCY-1];
                    first_err_data_d = rd_data;
                end else begin
                    first_err_addr_d = first_err_addr_q;
                end
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            check_count_d = check_count_q;
        end
        if (state_q == ST_REPORT) begin
            done_d = 1'b1;
            pass_d = (err_count_q == 16'd0) && (check_count_q == 20'(BRAM_SIZE));
        end else begin
            done_d = 1'b0;
        end
    end

    // State, statistics and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            drain_cnt_q      <= 3'd0;
            err_count_q      <= 16'd0;
            check_count_q    <= 20'd0;
            first_err_addr_q <= 20'd0;
            first_err_data_q <= 16'd0;
            pass_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            drain_cnt_q      <= drain_cnt_d;
            err_count_q      <= err_count_d;
            check_count_q    <= check_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            pass_q           <= pass_d;
            done_q           <= done_d;
        end
    end

    // Read-request shift line; flushed by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                line_addr_q[i] <= 20'd0;
            end
        end else begin
            line_vld_q[0]  <= push_s;
            line_addr_q[0] <= rd_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                line_vld_q[i]  <= line_vld_q[i-1];
                line_addr_q[i] <= line_addr_q[i-1];
            end
        end
    end

`ifdef BRAM_CHECKER_STICKY_FAIL_EN
    logic sticky_q, sticky_d;

    // Sticky flag sets on any failing verdict.
    always_comb begin
        sticky_d = sticky_q;
        if ((state_q == ST_REPORT) && !pass_d) begin
            sticky_d = 1'b1;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_fail = sticky_q;
`else
    assign sticky_fail = 1'b0;
`endif

    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign check_count    = check_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_bram_readback_checker.sv
// -----------------------------------------------------------------------------
// Testbench for bram_readback_checker. Two instances (RD_LATENCY 1 / SEED 0
// and RD_LATENCY 3 / SEED A5A5) share the read-port stimulus; each gets its
// own BRAM data pipeline. A per-pass list of issued reads is scored at the end
// of the pass and compared against the reported statistics.
// -----------------------------------------------------------------------------
module tb_bram_readback_checker;

    localparam int          BRAM_SIZE = 2048;
    localparam int          LAT_A     = 1;
    localparam int          LAT_B     = 3;
    localparam logic [15:0] SEED_A    = 16'h0000;
    localparam logic [15:0] SEED_B    = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rw_active, rd_en;
    logic [19:0] rd_addr;
    logic [15:0] cur_a, cur_b, data_a, data_b;
    logic [15:0] pipe_b [LAT_B];

    logic        done_a, pass_a, sticky_a, done_b, pass_b, sticky_b;
    logic [15:0] err_a, fed_a, err_b, fed_b;
    logic [19:0] cnt_a, fea_a, cnt_b, fea_b;

    int n_vec = 0;
    int n_err = 0;
    bit sticky_exp_a = 1'b0;
    bit sticky_exp_b = 1'b0;

    // Reads issued in the current pass.
    logic [19:0] addr_q [$];
    bit          bad_q  [$];
    logic [15:0] badv_q [$];

    bram_readback_checker #(.BRAM_SIZE(BRAM_SIZE), .RD_LATENCY(LAT_A), .SEED(SEED_A)) dut_a (
        .clk(clk), .rst(rst), .rw_active(rw_active), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(data_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .check_count(cnt_a), .first_err_addr(fea_a), .first_err_data(fed_a),
        .sticky_fail(sticky_a));

    bram_readback_checker #(.BRAM_SIZE(BRAM_SIZE), .RD_LATENCY(LAT_B), .SEED(SEED_B)) dut_b (
        .clk(clk), .rst(rst), .rw_active(rw_active), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(data_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .check_count(cnt_b), .first_err_addr(fea_b), .first_err_data(fed_b),
        .sticky_fail(sticky_b));

    // BRAM read-latency models.
    always @(posedge clk) begin
        data_a    <= cur_a;
        pipe_b[0] <= cur_b;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign data_b = pipe_b[LAT_B-1];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        rd_en   = 1'b0;
        rd_addr = 20'($urandom);
        cur_a   = 16'($urandom);
        cur_b   = 16'($urandom);
    endtask

    task automatic issue(input logic [19:0] addr, input bit bad, input logic [15:0] badv);
        rd_en   = 1'b1;
        rd_addr = addr;
        cur_a   = bad ? badv : addr[15:0] + SEED_A;
        cur_b   = bad ? badv : addr[15:0] + SEED_B;
        addr_q.push_back(addr);
        bad_q.push_back(bad);
        badv_q.push_back(badv);
    endtask

    // Score the pass: every read returning something other than addr+seed is an error.
    task automatic model(input logic [15:0] seed, output logic [15:0] e_err,
                         output logic [19:0] e_cnt, output logic [19:0] e_fa,
                         output logic [15:0] e_fd, output bit e_pass);
        int          mism;
        logic [15:0] d;
        logic [15:0] want;
        mism = 0;
        e_fa = 20'd0;
        e_fd = 16'd0;
        for (int i = 0; i < addr_q.size(); i++) begin
            want = addr_q[i][15:0] + seed;
            d    = bad_q[i] ? badv_q[i] : want;
            if (d != want) begin
                if (mism == 0) begin
                    e_fa = addr_q[i];
                    e_fd = d;
                end
                mism++;
            end
        end
        e_err  = (mism > 65535) ? 16'hFFFF : 16'(mism);
        e_cnt  = 20'(addr_q.size());
        e_pass = (mism == 0) && (addr_q.size() == BRAM_SIZE);
    endtask

    task automatic start_pass();
        addr_q.delete();
        bad_q.delete();
        badv_q.delete();
        rw_active = 1'b1;
        junk();
        rd_en = 1'b1;           // strobe while still IDLE must be ignored
        tick();
        junk();
    endtask

    task automatic run_reads(input int n, input int bad_idx, input logic [15:0] bad_val,
                             input bit gaps, input bit hi_rand, input bit rand_err,
                             input bit last_on_final);
        logic [19:0] addr;
        bit          bad;
        logic [15:0] badv;
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 7) == 0)) begin
                junk();
                repeat ($urandom_range(1, 3)) tick();
            end
            addr = {hi_rand ? 4'($urandom) : 4'h0, 16'(i)};
            bad  = (i == bad_idx) || (rand_err && ($urandom_range(0, 99) == 0));
            badv = (i == bad_idx) ? bad_val : 16'($urandom);
            issue(addr, bad, badv);
            if (last_on_final && (i == n - 1)) begin
                rw_active = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    task automatic check_report(input string tag, input logic p, input logic [15:0] er,
                                input logic [19:0] cn, input logic [19:0] fa,
                                input logic [15:0] fd, input logic st, input bit e_p,
                                input logic [15:0] e_er, input logic [19:0] e_cn,
                                input logic [19:0] e_fa, input logic [15:0] e_fd, input bit e_st);
        check_val({tag, ".pass"}, 32'(p), 32'(e_p));
        check_val({tag, ".err_count"}, 32'(er), 32'(e_er));
        check_val({tag, ".check_count"}, 32'(cn), 32'(e_cn));
        check_val({tag, ".first_err_addr"}, 32'(fa), 32'(e_fa));
        check_val({tag, ".first_err_data"}, 32'(fd), 32'(e_fd));
        check_val({tag, ".sticky_fail"}, 32'(st), 32'(e_st));
    endtask

    task automatic finish_pass(input string name, input bit last_on_final, input bit drain_junk);
        logic [15:0] er_a, er_b, fd_a, fd_b;
        logic [19:0] cn_a, cn_b, fa_a, fa_b;
        bit          p_a, p_b;
        int          lat_a, lat_b, nd_a, nd_b;
        if (!last_on_final) begin
            junk();
            rw_active = 1'b0;
        end
        model(SEED_A, er_a, cn_a, fa_a, fd_a, p_a);
        model(SEED_B, er_b, cn_b, fa_b, fd_b, p_b);
`ifdef BRAM_CHECKER_STICKY_FAIL_EN
        sticky_exp_a = sticky_exp_a | !p_a;
        sticky_exp_b = sticky_exp_b | !p_b;
`endif
        lat_a = 0; lat_b = 0; nd_a = 0; nd_b = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done_a) begin
                nd_a++;
                if (lat_a == 0) begin
                    lat_a = k;
                    check_report({name, ".a"}, pass_a, err_a, cnt_a, fea_a, fed_a, sticky_a,
                                 p_a, er_a, cn_a, fa_a, fd_a, sticky_exp_a);
                end
            end
            if (done_b) begin
                nd_b++;
                if (lat_b == 0) begin
                    lat_b = k;
                    check_report({name, ".b"}, pass_b, err_b, cnt_b, fea_b, fed_b, sticky_b,
                                 p_b, er_b, cn_b, fa_b, fd_b, sticky_exp_b);
                end
            end
            tick();
            junk();
            if (drain_junk && (k == 1)) begin
                rd_en = 1'b1;   // protocol violation in DRAIN, must be ignored
            end
        end
        // Sample index k counts from the cycle in which rw_active is low:
        // done appears after edge M+LAT+1, i.e. at k = LAT+3.
        check_val({name, ".a.done_latency"}, 32'(lat_a), 32'(LAT_A + 3));
        check_val({name, ".b.done_latency"}, 32'(lat_b), 32'(LAT_B + 3));
        check_val({name, ".a.done_pulses"}, 32'(nd_a), 32'd1);
        check_val({name, ".b.done_pulses"}, 32'(nd_b), 32'd1);
        check_val({name, ".a.pass_held"}, 32'(pass_a), 32'(p_a));
        check_val({name, ".b.pass_held"}, 32'(pass_b), 32'(p_b));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".a.outs"}, {done_a, pass_a, sticky_a, err_a, cnt_a, fea_a, fed_a} == '0 ? 32'd0 : 32'd1, 32'd0);
        check_val({tag, ".b.outs"}, {done_b, pass_b, sticky_b, err_b, cnt_b, fea_b, fed_b} == '0 ? 32'd0 : 32'd1, 32'd0);
        check_val({tag, ".a.check_count"}, 32'(cnt_a), 32'd0);
        check_val({tag, ".b.err_count"}, 32'(err_b), 32'd0);
    endtask

    initial begin
        int nd;
        rst       = 1'b0;
        rw_active = 1'b0;
        junk();
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        tick();

        start_pass(); run_reads(BRAM_SIZE, -1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_pass("clean", 1'b0, 1'b0);

        start_pass(); run_reads(BRAM_SIZE, 100, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_pass("corrupt100", 1'b0, 1'b0);

        start_pass(); run_reads(BRAM_SIZE - 1, -1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_pass("short", 1'b0, 1'b0);

        start_pass(); repeat (4) tick();
        finish_pass("zero_reads", 1'b0, 1'b0);

        start_pass(); run_reads(BRAM_SIZE, -1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        finish_pass("clean_gaps", 1'b0, 1'b0);

        start_pass(); run_reads(BRAM_SIZE, BRAM_SIZE - 1, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        finish_pass("last_on_final", 1'b1, 1'b1);

        start_pass(); run_reads(BRAM_SIZE, -1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        finish_pass("rand_err", 1'b0, 1'b1);

        // Reset in the middle of a pass: everything returns to zero, no done.
        start_pass(); run_reads(500, 7, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
        rst       = 1'b0;
        rw_active = 1'b0;
        junk();
        tick();
        rst = 1'b1;
        sticky_exp_a = 1'b0;
        sticky_exp_b = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            if (done_a || done_b) nd++;
        end
        check_val("mid_reset.no_done", 32'(nd), 32'd0);
        tick();

        start_pass(); run_reads(BRAM_SIZE, -1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_pass("after_reset", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
